// File: rtl/mem_io_pkg.sv
// Shared constants, FSM state type and address-decode helper for the memory/I-O responder.
// Optional feature macro: MEM_IO_CLK_CNT_EN (cycle counter and snapshot latch).
package mem_io_pkg;

    localparam logic [1:0]  IO_SEL       = 2'b11;
    localparam logic [31:0] IO_UART_ADDR = 32'h0003_0000;
    localparam logic [31:0] IO_CLK_ADDR  = 32'h0003_0004;

    typedef enum logic [0:0] {
        IDLE,
        WAIT
    } rx_state_e;

    function automatic logic is_io_addr(input logic [31:0] addr);
        return addr[17:16] == IO_SEL;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU-side byte-wide memory bus: address/write data/strobe from the CPU,
// read data plus flow-control flags back from the responder.
interface mem_io_responder_if;

    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        cpu_rdy;

    modport master (
        output mem_a,
        output mem_dout,
        output mem_wr,
        input  mem_din,
        input  io_buffer_full,
        input  cpu_rdy
    );

    modport slave (
        input  mem_a,
        input  mem_dout,
        input  mem_wr,
        output mem_din,
        output io_buffer_full,
        output cpu_rdy
    );

endinterface

// File: rtl/mem_io_tx_fifo.sv
// Circular-buffer byte FIFO feeding the UART TX stream; reports full, nearly-full
// (one slot of slack) and empty, and flags pushes dropped on a full buffer.
module mem_io_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_full,
    output logic       o_nearly_full,
    output logic       o_empty,
    output logic       o_drop
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   FULL_LVL = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   NF_LVL   = (PW + 1)'(DEPTH - 1);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_nearly_full;
    logic [PW:0]   w_count_d;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_LVL);
    assign w_pop   = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a push on full is still accepted.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_drop  = i_push && o_full && !w_pop;
    assign o_head  = o_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign o_nearly_full = r_nearly_full;

    always_comb begin
        w_count_d = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CNT_ONE;
            2'b01:   w_count_d = r_count - CNT_ONE;
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_nearly_full <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count       <= w_count_d;
            r_nearly_full <= (w_count_d >= NF_LVL);
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory and I/O responder for the CPU byte bus: inferred RAM, UART TX FIFO / blocking RX,
// program-stop flag and, when MEM_IO_CLK_CNT_EN is defined, a snapshot-able cycle counter.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WID = 17,
    parameter int unsigned TX_DEPTH     = 8
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    mem_io_responder_if.slave   bus,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                prog_stop,
    output logic                tx_overflow
);

    localparam int unsigned RAM_BYTES = 1 << RAM_ADDR_WID;

    logic [7:0]  r_ram [RAM_BYTES];
    rx_state_e   r_state;
    logic [7:0]  r_mem_din;
    logic        r_cpu_rdy;
    logic        r_prog_stop;
    logic        r_tx_overflow;
`ifdef MEM_IO_CLK_CNT_EN
    logic [31:0] r_cnt;
    logic [31:0] r_cnt_latch;
    logic        w_clk_rd;
`endif

    logic [RAM_ADDR_WID-1:0] w_ram_addr;
    logic [7:0]  w_ram_rdata;
    logic        w_active;
    logic        w_is_io;
    logic        w_ram_wr;
    logic        w_uart_rd;
    logic        w_uart_wr;
    logic        w_stop_wr;
    logic        w_rx_fire;
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic        w_fifo_nf;
    logic        w_fifo_drop;

    // While paused the CPU holds its address; only the first cycle of an access acts.
    assign w_active   = (r_state == IDLE);
    assign w_is_io    = is_io_addr(bus.mem_a);
    assign w_ram_addr = bus.mem_a[RAM_ADDR_WID-1:0];
    assign w_ram_wr   = w_active && !w_is_io && bus.mem_wr;
    assign w_uart_rd  = w_active && w_is_io && !bus.mem_wr && (bus.mem_a == IO_UART_ADDR);
    assign w_uart_wr  = w_active && w_is_io && bus.mem_wr && (bus.mem_a == IO_UART_ADDR);
    assign w_stop_wr  = w_active && w_is_io && bus.mem_wr && (bus.mem_a == IO_CLK_ADDR);
`ifdef MEM_IO_CLK_CNT_EN
    assign w_clk_rd   = w_active && w_is_io && !bus.mem_wr
                        && (bus.mem_a[31:2] == IO_CLK_ADDR[31:2]);
`endif

    // Gated by reset so the handshake line is quiet while reset is held.
    assign rx_ready  = rst_n_in && ((r_state == WAIT) || w_uart_rd);
    assign w_rx_fire = rx_valid && rx_ready;

    assign bus.mem_din        = r_mem_din;
    assign bus.cpu_rdy        = r_cpu_rdy;
    assign bus.io_buffer_full = w_fifo_nf;
    assign tx_valid           = !w_fifo_empty;
    assign prog_stop          = r_prog_stop;
    assign tx_overflow        = r_tx_overflow;

    assign w_ram_rdata = r_ram[w_ram_addr];

    always_ff @(posedge clk_in) begin
        if (w_ram_wr) begin
            r_ram[w_ram_addr] <= bus.mem_dout;
        end
    end

    mem_io_tx_fifo #(
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .i_push       (w_uart_wr && (bus.mem_dout != 8'h00)),
        .i_push_data  (bus.mem_dout),
        .i_pop        (tx_ready),
        .o_head       (tx_data),
        .o_full       (w_fifo_full),
        .o_nearly_full(w_fifo_nf),
        .o_empty      (w_fifo_empty),
        .o_drop       (w_fifo_drop)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= IDLE;
            r_mem_din     <= 8'h00;
            r_cpu_rdy     <= 1'b1;
            r_prog_stop   <= 1'b0;
            r_tx_overflow <= 1'b0;
`ifdef MEM_IO_CLK_CNT_EN
            r_cnt         <= 32'd0;
            r_cnt_latch   <= 32'd0;
`endif
        end else begin
`ifdef MEM_IO_CLK_CNT_EN
            r_cnt <= r_cnt + 32'd1;
`endif
            if (w_stop_wr) begin
                r_prog_stop <= 1'b1;
            end
            if (w_fifo_drop) begin
                r_tx_overflow <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_uart_rd) begin
                        if (rx_valid) begin
                            r_mem_din <= rx_data;
                        end else begin
                            r_state   <= WAIT;
                            r_cpu_rdy <= 1'b0;
                        end
`ifdef MEM_IO_CLK_CNT_EN
                    end else if (w_clk_rd) begin
                        unique case (bus.mem_a[1:0])
                            2'd0: begin
                                r_cnt_latch <= r_cnt;
                                r_mem_din   <= r_cnt[7:0];
                            end
                            2'd1:    r_mem_din <= r_cnt_latch[15:8];
                            2'd2:    r_mem_din <= r_cnt_latch[23:16];
                            default: r_mem_din <= r_cnt_latch[31:24];
                        endcase
`endif
                    end else if (w_is_io) begin
                        r_mem_din <= 8'h00;
                    end else begin
                        r_mem_din <= w_ram_rdata;
                    end
                end
                WAIT: begin
                    if (w_rx_fire) begin
                        r_state   <= IDLE;
                        r_cpu_rdy <= 1'b1;
                        r_mem_din <= rx_data;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder; inputs change and outputs are
// sampled on the falling clock edge. Honours MEM_IO_CLK_CNT_EN for the counter reads.
module tb_mem_io_responder;

    logic       clk_in;
    logic       rst_n_in;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       prog_stop;
    logic       tx_overflow;

    mem_io_responder_if bus ();

    mem_io_responder #(
        .RAM_ADDR_WID(17),
        .TX_DEPTH    (8)
    ) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .bus        (bus),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .prog_stop  (prog_stop),
        .tx_overflow(tx_overflow)
    );

    int          checks = 0;
    int          errors = 0;
    int          tx_n   = 0;
    int          rx_hs  = 0;
    logic [7:0]  tx_log [0:31];
    logic [31:0] tb_cyc;
    logic [31:0] snap_exp;
    logic [31:0] snap_got;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) tb_cyc <= 32'd0;
        else           tb_cyc <= tb_cyc + 32'd1;
    end

    always @(posedge clk_in) begin
        if (rst_n_in && tx_valid && tx_ready) begin
            if (tx_n < 32) tx_log[tx_n] = tx_data;
            tx_n = tx_n + 1;
        end
        if (rst_n_in && rx_valid && rx_ready) rx_hs = rx_hs + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
        bus.mem_a    = a;
        bus.mem_dout = d;
        bus.mem_wr   = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic bus_rd(input logic [31:0] a);
        bus.mem_a  = a;
        bus.mem_wr = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic idle(input int n);
        bus.mem_a  = 32'h0000_0100;
        bus.mem_wr = 1'b0;
        repeat (n) @(negedge clk_in);
    endtask

    initial begin
        rst_n_in     = 1'b0;
        bus.mem_a    = 32'h0;
        bus.mem_dout = 8'h00;
        bus.mem_wr   = 1'b0;
        tx_ready     = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        repeat (2) @(negedge clk_in);

        check("rst_mem_din", {24'h0, bus.mem_din}, 32'h00);
        check("rst_cpu_rdy", {31'h0, bus.cpu_rdy}, 32'h1);
        check("rst_buf_full", {31'h0, bus.io_buffer_full}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h00);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("rst_prog_stop", {31'h0, prog_stop}, 32'h0);
        check("rst_tx_ovf", {31'h0, tx_overflow}, 32'h0);
        rst_n_in = 1'b1;
        idle(2);

        // RAM write then read, including the top byte of the 128 KB space
        bus_wr(32'h0001_0010, 8'hA5);
        bus_wr(32'h0001_FFFF, 8'h3C);
        bus_rd(32'h0001_0010);
        check("ram_rd_a5", {24'h0, bus.mem_din}, 32'hA5);
        bus_rd(32'h0001_FFFF);
        check("ram_rd_top", {24'h0, bus.mem_din}, 32'h3C);
        bus_rd(32'h0003_0008);
        check("io_other_rd", {24'h0, bus.mem_din}, 32'h00);

        // TX: zero byte is skipped
        tx_ready = 1'b1;
        bus_wr(32'h0003_0000, 8'h41);
        bus_wr(32'h0003_0000, 8'h00);
        bus_wr(32'h0003_0000, 8'h42);
        idle(4);
        check("tx_count2", tx_n, 2);
        check("tx_byte0", {24'h0, tx_log[0]}, 32'h41);
        check("tx_byte1", {24'h0, tx_log[1]}, 32'h42);
        check("tx_drained", {31'h0, tx_valid}, 32'h0);

        // TX fill: nearly-full after 7, 8th accepted, 9th dropped
        tx_ready = 1'b0;
        for (int i = 1; i <= 6; i++) bus_wr(32'h0003_0000, 8'(i));
        check("nf_after6", {31'h0, bus.io_buffer_full}, 32'h0);
        bus_wr(32'h0003_0000, 8'h07);
        check("nf_after7", {31'h0, bus.io_buffer_full}, 32'h1);
        bus_wr(32'h0003_0000, 8'h08);
        check("ovf_after8", {31'h0, tx_overflow}, 32'h0);
        bus_wr(32'h0003_0000, 8'h09);
        check("ovf_after9", {31'h0, tx_overflow}, 32'h1);
        idle(1);
        tx_ready = 1'b1;
        idle(12);
        check("drain_count", tx_n, 10);
        check("drain_first", {24'h0, tx_log[2]}, 32'h01);
        check("drain_last", {24'h0, tx_log[9]}, 32'h08);
        check("nf_cleared", {31'h0, bus.io_buffer_full}, 32'h0);
        check("ovf_sticky", {31'h0, tx_overflow}, 32'h1);

        // RX blocking read: 5 cycles of no data, then 0x7E
        bus_rd(32'h0003_0000);
        for (int i = 0; i < 4; i++) begin
            check("rx_wait_rdy", {31'h0, bus.cpu_rdy}, 32'h0);
            check("rx_wait_ready", {31'h0, rx_ready}, 32'h1);
            @(negedge clk_in);
        end
        check("rx_wait_rdy5", {31'h0, bus.cpu_rdy}, 32'h0);
        rx_valid = 1'b1;
        rx_data  = 8'h7E;
        @(negedge clk_in);
        check("rx_rdy_up", {31'h0, bus.cpu_rdy}, 32'h1);
        check("rx_data_7e", {24'h0, bus.mem_din}, 32'h7E);
        rx_valid = 1'b0;
        idle(3);
        check("rx_one_hs", rx_hs, 1);
        check("rx_rdy_held", {31'h0, bus.cpu_rdy}, 32'h1);

        // RX immediate: byte already waiting
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        bus_rd(32'h0003_0000);
        rx_valid = 1'b0;
        check("rx_imm_data", {24'h0, bus.mem_din}, 32'h55);
        check("rx_imm_rdy", {31'h0, bus.cpu_rdy}, 32'h1);
        idle(2);
        check("rx_imm_hs", rx_hs, 2);

        // Counter snapshot around cycle 1000
        bus.mem_a = 32'h0000_0100;
        for (int i = 0; i < 2000 && tb_cyc < 32'd1000; i++) @(negedge clk_in);
        snap_exp = tb_cyc;
        bus_rd(32'h0003_0004);
        snap_got[7:0] = bus.mem_din;
        bus_rd(32'h0003_0005);
        snap_got[15:8] = bus.mem_din;
        bus_rd(32'h0003_0006);
        snap_got[23:16] = bus.mem_din;
        bus_rd(32'h0003_0007);
        snap_got[31:24] = bus.mem_din;
`ifdef MEM_IO_CLK_CNT_EN
        check("cnt_snapshot", snap_got, snap_exp);
`else
        check("cnt_absent", snap_got, 32'h0);
`endif
        idle(1);

        // Program stop is sticky and does not touch the TX FIFO
        bus_wr(32'h0003_0004, 8'h00);
        check("stop_set", {31'h0, prog_stop}, 32'h1);
        idle(3);
        check("stop_held", {31'h0, prog_stop}, 32'h1);
        check("stop_no_tx", {31'h0, tx_valid}, 32'h0);

        // Async reset in the middle of a blocking read
        bus_rd(32'h0001_0010);
        bus_rd(32'h0003_0000);
        @(negedge clk_in);
        check("wait_before_rst", {31'h0, bus.cpu_rdy}, 32'h0);
        check("din_before_rst", {24'h0, bus.mem_din}, 32'hA5);
        #2 rst_n_in = 1'b0;
        #1;
        check("arst_cpu_rdy", {31'h0, bus.cpu_rdy}, 32'h1);
        check("arst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("arst_mem_din", {24'h0, bus.mem_din}, 32'h00);
        check("arst_prog_stop", {31'h0, prog_stop}, 32'h0);
        check("arst_tx_ovf", {31'h0, tx_overflow}, 32'h0);
        check("arst_buf_full", {31'h0, bus.io_buffer_full}, 32'h0);
        check("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
        @(negedge clk_in);
        bus.mem_a = 32'h0000_0100;
        rst_n_in  = 1'b1;
        idle(2);
        check("post_rst_rdy", {31'h0, bus.cpu_rdy}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
